// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game core: state codes,
// LFSR tap mask and constant helpers used to size registers.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        PREPARA  = 4'h1,
        MOSTRA   = 4'h2,
        APAGADO  = 4'h3,
        ESPERA   = 4'h4,
        REGISTRA = 4'h5,
        COMPARA  = 4'h6,
        NOVA     = 4'h7,
        GANHOU   = 4'hD,
        PERDEU   = 4'hE
    } estado_t;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; holds at M-1 and flags it.
module contador_m
    import jogo_pkg::*;
#(
    parameter int unsigned M = 16,
    localparam int unsigned W = (M > 1) ? clog2(M) : 1
) (
    input  logic         clock,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] valor,
    output logic         fim
);

    assign fim = (valor == W'(M - 1));

    always_ff @(posedge clock) begin
        if (zera)
            valor <= '0;
        else if (conta && !fim)
            valor <= valor + W'(1);
    end

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game core: grows a move sequence each round, replays it
// on the LEDs and checks the player's repetition against it.
module jogo_sequencia_param
    import jogo_pkg::*;
#(
    parameter int unsigned N_BOTOES    = 4,
    parameter int unsigned MAX_RODADAS = 16,
    parameter int unsigned T_LED       = 1000,
    parameter int unsigned T_APAGADO   = 250,
    parameter int unsigned T_TIMEOUT   = 5000,
    parameter logic [7:0]  SEMENTE     = 8'hA5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                modo,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [3:0]          db_estado,
    output logic [3:0]          db_rodada,
    output logic [3:0]          db_jogada
);

    localparam int unsigned WB  = clog2(N_BOTOES);
    localparam int unsigned WR  = clog2(MAX_RODADAS);
    localparam int unsigned M_T = max3(T_LED, T_APAGADO, T_TIMEOUT);
    localparam int unsigned WC  = (M_T > 1) ? clog2(M_T) : 1;

    estado_t             estado;
    logic [WR-1:0]       rodada, idx;
    logic [WB-1:0]       jogada_r;
    logic                modo_r, timeout_r;
    logic [7:0]          lfsr;
    logic [N_BOTOES-1:0] botoes_q;
    logic                botoes_qq;
    logic                jogada, multi;
    logic [WB-1:0]       botao_idx, v_lfsr;
    logic [WB-1:0]       mem [MAX_RODADAS];
    logic [WC-1:0]       valor, lim;
    logic                fim, temporizado, fim_estado, zera;

    function automatic logic [WR-1:0] sat_inc(input logic [WR-1:0] x);
        return (x == WR'(MAX_RODADAS - 1)) ? x : x + WR'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr      <= SEMENTE;
            botoes_q  <= '0;
            botoes_qq <= 1'b0;
        end else begin
            lfsr      <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            botoes_q  <= botoes;
            botoes_qq <= |botoes_q;
        end
    end

    assign jogada = (|botoes_q) & ~botoes_qq;
    assign multi  = |(botoes_q & (botoes_q - N_BOTOES'(1)));

    always_comb begin
        botao_idx = '0;
        for (int unsigned i = 0; i < N_BOTOES; i++)
            if (botoes_q[i]) botao_idx = WB'(i);
        v_lfsr = lfsr[WB-1:0];
        if (32'(v_lfsr) >= N_BOTOES) v_lfsr = v_lfsr - WB'(N_BOTOES);
    end

    // One timer serves all timed states; it is cleared whenever the current
    // interval ends or the FSM sits in an untimed state, so every entry starts at 0.
    always_comb begin
        case (estado)
            MOSTRA:  lim = WC'(T_LED - 1);
            APAGADO: lim = WC'(T_APAGADO - 1);
            default: lim = WC'(T_TIMEOUT - 1);
        endcase
        temporizado = (estado == MOSTRA) || (estado == APAGADO) || (estado == ESPERA);
        fim_estado  = (temporizado && (valor == lim)) || fim;
        zera        = reset || !temporizado || fim_estado;
    end

    contador_m #(.M(M_T)) u_timer (
        .clock (clock),
        .zera  (zera),
        .conta (temporizado),
        .valor (valor),
        .fim   (fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= INICIAL;
            rodada    <= '0;
            idx       <= '0;
            jogada_r  <= '0;
            modo_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (estado)
                INICIAL, GANHOU, PERDEU: if (jogar) begin
                    estado    <= PREPARA;
                    rodada    <= '0;
                    idx       <= '0;
                    jogada_r  <= '0;
                    timeout_r <= 1'b0;
                    modo_r    <= modo;
                    mem[0]    <= v_lfsr;
                end
                PREPARA: estado <= MOSTRA;
                MOSTRA:  if (fim_estado) estado <= APAGADO;
                APAGADO: if (fim_estado) begin
                    if (idx == rodada) begin
                        estado <= ESPERA;
                        idx    <= '0;
                    end else begin
                        estado <= MOSTRA;
                        idx    <= sat_inc(idx);
                    end
                end
                ESPERA: begin
                    if (jogada) begin
                        if (multi) estado <= PERDEU;
                        else begin
                            jogada_r <= botao_idx;
                            estado   <= REGISTRA;
                        end
                    end else if (fim_estado) begin
                        estado    <= PERDEU;
                        timeout_r <= 1'b1;
                    end
                end
                REGISTRA: estado <= COMPARA;
                COMPARA: begin
                    if (jogada_r != mem[idx]) estado <= PERDEU;
                    else if (idx != rodada) begin
                        idx    <= sat_inc(idx);
                        estado <= ESPERA;
                    end else if (rodada == WR'(MAX_RODADAS - 1)) estado <= GANHOU;
                    else estado <= NOVA;
                end
                NOVA: begin
                    if (!modo_r) begin
                        mem[sat_inc(rodada)] <= v_lfsr;
                        rodada <= sat_inc(rodada);
                        idx    <= '0;
                        estado <= MOSTRA;
                    end else if (jogada) begin
                        if (multi) estado <= PERDEU;
                        else begin
                            mem[sat_inc(rodada)] <= botao_idx;
                            jogada_r <= botao_idx;
                            rodada   <= sat_inc(rodada);
                            idx      <= '0;
                            estado   <= MOSTRA;
                        end
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    assign leds       = botoes | ((estado == MOSTRA) ? (N_BOTOES'(1) << mem[idx]) : '0);
    assign pronto     = (estado == GANHOU) || (estado == PERDEU);
    assign ganhou     = (estado == GANHOU);
    assign perdeu     = (estado == PERDEU);
    assign db_timeout = timeout_r;
    assign db_estado  = estado;
    assign db_rodada  = 4'(rodada);
    assign db_jogada  = 4'(jogada_r);

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Directed game scenarios with randomized delays and buttons, checked against
// a move-list model of the game (LFSR mirror plus expected per-cycle LEDs).
module tb_jogo_sequencia_param;

    localparam int N    = 4;
    localparam int MAXR = 2;
    localparam int TL   = 4;
    localparam int TA   = 2;
    localparam int TT   = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       jogar = 1'b0;
    logic       modo  = 1'b0;
    logic [3:0] botoes = '0;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado, db_rodada, db_jogada;

    int         n_checks = 0;
    int         n_err    = 0;
    int         seq [MAXR];
    logic [7:0] lfsr_m;

    jogo_sequencia_param #(
        .N_BOTOES    (N),
        .MAX_RODADAS (MAXR),
        .T_LED       (TL),
        .T_APAGADO   (TA),
        .T_TIMEOUT   (TT),
        .SEMENTE     (8'hA5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .jogar      (jogar),
        .modo       (modo),
        .botoes     (botoes),
        .leds       (leds),
        .pronto     (pronto),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .db_timeout (db_timeout),
        .db_estado  (db_estado),
        .db_rodada  (db_rodada),
        .db_jogada  (db_jogada)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    function automatic int next_move(input logic [7:0] l);
        int v;
        v = int'(l) % 4;
        if (v >= N) v = v - N;
        return v;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start(input logic m, input int idle);
        tick(idle);
        modo   = m;
        jogar  = 1'b1;
        seq[0] = next_move(lfsr_m);
        tick(1);
        jogar = 1'b0;
        modo  = 1'($urandom_range(0, 1));
        chk("prepara", db_estado, 4'h1);
        chk("prepara_pronto", pronto, 1'b0);
    endtask

    task automatic replay(input int r);
        for (int i = 0; i <= r; i++) begin
            repeat (TL) begin
                tick(1);
                chk("led_on", leds, onehot(seq[i]));
            end
            repeat (TA) begin
                tick(1);
                chk("led_off", leds, 4'h0);
            end
        end
        tick(1);
        chk("espera", db_estado, 4'h4);
    endtask

    task automatic press(input logic [3:0] b, input int idx);
        botoes = b;
        tick(1);
        botoes = '0;
        tick(2);
        chk("compara", db_estado, 4'h6);
        chk("db_jogada", db_jogada, 32'(idx));
        tick(1);
    endtask

    initial begin
        int w;
        logic [3:0] r;

        // 1: reset
        botoes = 4'($urandom_range(1, 15));
        repeat (3) begin
            tick(1);
            chk("rst_estado", db_estado, 4'h0);
            chk("rst_leds", leds, botoes);
        end
        chk("rst_pronto", pronto, 1'b0);
        chk("rst_ganhou", ganhou, 1'b0);
        chk("rst_perdeu", perdeu, 1'b0);
        botoes = '0;
        tick(1);
        reset = 1'b0;
        tick(2);

        // 2: LFSR mode, win
        start(1'b0, $urandom_range(0, 5));
        replay(0);
        tick($urandom_range(0, 5));
        press(onehot(seq[0]), seq[0]);
        chk("nova", db_estado, 4'h7);
        seq[1] = next_move(lfsr_m);
        replay(1);
        chk("rodada1", db_rodada, 4'h1);
        press(onehot(seq[0]), seq[0]);
        chk("espera_r1", db_estado, 4'h4);
        tick($urandom_range(0, 5));
        press(onehot(seq[1]), seq[1]);
        chk("ganhou_estado", db_estado, 4'hD);
        chk("ganhou", ganhou, 1'b1);
        chk("ganhou_pronto", pronto, 1'b1);
        chk("ganhou_perdeu", perdeu, 1'b0);
        chk("ganhou_rodada", db_rodada, 4'h1);
        tick(3);
        chk("ganhou_hold", ganhou, 1'b1);

        // 3: wrong button in round 0
        start(1'b0, $urandom_range(0, 5));
        replay(0);
        w = (seq[0] + 1 + int'($urandom_range(0, 2))) % N;
        press(onehot(w), w);
        chk("erro_estado", db_estado, 4'hE);
        chk("erro_perdeu", perdeu, 1'b1);
        chk("erro_timeout", db_timeout, 1'b0);
        chk("erro_pronto", pronto, 1'b1);
        chk("erro_ganhou", ganhou, 1'b0);

        // 4: timeout
        start(1'b0, $urandom_range(0, 5));
        replay(0);
        tick(TT - 1);
        chk("to_ainda_espera", db_estado, 4'h4);
        tick(1);
        chk("to_estado", db_estado, 4'hE);
        chk("to_perdeu", perdeu, 1'b1);
        chk("to_flag", db_timeout, 1'b1);

        // 5: player-appended move
        start(1'b1, $urandom_range(0, 5));
        chk("timeout_limpo", db_timeout, 1'b0);
        replay(0);
        press(onehot(seq[0]), seq[0]);
        chk("nova_m1", db_estado, 4'h7);
        tick($urandom_range(0, 12));
        chk("nova_m1_espera", db_estado, 4'h7);
        botoes = 4'b1000;
        tick(1);
        botoes = '0;
        chk("nova_m1_jogada", db_estado, 4'h7);
        seq[1] = 3;
        replay(1);
        chk("nova_m1_db_jogada", db_jogada, 4'h3);
        press(onehot(seq[0]), seq[0]);
        press(4'b1000, 3);
        chk("m1_ganhou", ganhou, 1'b1);
        chk("m1_pronto", pronto, 1'b1);

        // 6: multi-press, then reset mid-replay
        start(1'b0, $urandom_range(0, 5));
        replay(0);
        botoes = 4'b0011;
        tick(1);
        botoes = '0;
        tick(1);
        chk("multi_estado", db_estado, 4'hE);
        chk("multi_perdeu", perdeu, 1'b1);
        chk("multi_timeout", db_timeout, 1'b0);

        start(1'b0, $urandom_range(0, 5));
        tick($urandom_range(1, TL));
        chk("mid_mostra", leds, onehot(seq[0]));
        reset = 1'b1;
        botoes = 4'($urandom_range(1, 15));
        tick(1);
        chk("rst2_estado", db_estado, 4'h0);
        chk("rst2_leds", leds, botoes);
        chk("rst2_pronto", pronto, 1'b0);
        chk("rst2_rodada", db_rodada, 4'h0);
        chk("rst2_jogada", db_jogada, 4'h0);
        botoes = '0;
        tick(1);
        reset = 1'b0;
        tick(2);

        // after reset the LFSR restarts from the seed
        start(1'b0, $urandom_range(0, 5));
        replay(0);
        press(onehot(seq[0]), seq[0]);
        chk("pos_reset_nova", db_estado, 4'h7);

        r = 4'h0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + int'(r));
        $finish;
    end

endmodule
